muldiv_seq: RTL and testbench

- Iterative sequencer for the RV32M multiply/divide instructions, sitting beside the main ALU in the execute stage.
- Latches operands on a start handshake and runs one shift-add (multiply) or restoring-subtract (divide) step per cycle.
- Asserts stall_o to freeze the pipeline while it works, then presents a one-cycle done_o pulse with the result.
- Divide-by-zero and signed overflow are resolved without iterating.

---
 rtl/muldiv_seq_pkg.sv | 33 +++
 rtl/muldiv_seq_if.sv | 31 +++
 rtl/muldiv_seq_step.sv | 49 ++++
 rtl/muldiv_seq.sv | 159 +++++++++++++++
 tb/tb_muldiv_seq.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// Purpose: shared constants and types for the RV32M multiply/divide sequencer.
// Contents: default operand width, RV32M funct3 encodings, FSM state encoding,
//           and signedness decode helpers.
package muldiv_seq_pkg;

    localparam int unsigned DEF_XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // rs1 is treated as signed for MULH, MULHSU, DIV, REM
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV, REM
    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Purpose: request/response bundle between the execute stage and muldiv_seq.
// Signals: start_i, funct3_i, op_a_i, op_b_i, flush_i (towards the unit);
//          ready_o, stall_o, done_o, result_o (from the unit).
// Modports: master = execute stage side, slave = muldiv_seq side.
interface muldiv_seq_if
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
);

    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            flush_i;
    logic            ready_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, op_a_i, op_b_i, flush_i,
        input  ready_o, stall_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, op_a_i, op_b_i, flush_i,
        output ready_o, stall_o, done_o, result_o
    );

endinterface

// File: rtl/muldiv_seq_step.sv
// Purpose: one combinational iteration of the multiply/divide datapath.
// Ports: is_div_i  - 1: restoring-divide step, 0: shift-add multiply step
//        acc_i     - {upper, lower} accumulator; multiply: {partial, multiplier},
//                    divide: {remainder, quotient/dividend}
//        opnd_i    - multiplicand (multiply) or divisor (divide), magnitude
//        acc_o     - accumulator after this iteration (combinational)
module muldiv_step
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    localparam int unsigned AW = 2 * XLEN;

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        // Multiply: carry out of the upper-half add becomes the new MSB after the shift
        sum    = {1'b0, acc_i[AW-1:XLEN]} + {1'b0, opnd_i};
        // Divide: remainder after shifting in the next dividend bit, one bit wider
        rem_sh = acc_i[AW-1:XLEN-1];
        ge     = rem_sh >= {1'b0, opnd_i};
        // True difference is below 2^XLEN whenever ge holds, so the low bits suffice
        diff   = rem_sh[XLEN-1:0] - opnd_i;
        acc_o  = acc_i;
        if (is_div_i) begin
            if (ge) begin
                acc_o = {diff, acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc_i[0]) begin
                acc_o = {sum, acc_i[XLEN-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[AW-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Purpose: iterative RV32M multiply/divide sequencer for the execute stage.
// Ports: clk    - rising-edge clock
//        rst_n  - synchronous active-low reset
//        bus    - muldiv_seq_if.slave: start/funct3/operands/flush in,
//                 ready/stall/done/result out
// One accumulator step per BUSY cycle; divide-by-zero and signed overflow
// skip straight to DONE.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);

    localparam int unsigned AW = 2 * XLEN;
    localparam int unsigned CW = $clog2(XLEN + 1);

    state_e            state_q, state_d;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   opnd_q;
    logic [AW-1:0]     acc_q;
    logic [AW-1:0]     acc_step;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;

    // Accept-cycle decode
    logic              accept;
    logic              is_div;
    logic              sa, sb;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, ovf, special;
    logic              neg;

    // Result fix-up
    logic [AW-1:0]     prod;
    logic [XLEN-1:0]   quot, rem;
    logic [XLEN-1:0]   res_fix;

    always_comb begin
        is_div   = bus.funct3_i[2];
        sa       = a_is_signed(bus.funct3_i) & bus.op_a_i[XLEN-1];
        sb       = b_is_signed(bus.funct3_i) & bus.op_b_i[XLEN-1];
        abs_a    = sa ? (XLEN'(0) - bus.op_a_i) : bus.op_a_i;
        abs_b    = sb ? (XLEN'(0) - bus.op_b_i) : bus.op_b_i;
        div_zero = is_div & (bus.op_b_i == '0);
        ovf      = ((bus.funct3_i == F3_DIV) || (bus.funct3_i == F3_REM))
                 & (bus.op_a_i == {1'b1, {(XLEN-1){1'b0}}})
                 & (bus.op_b_i == '1);
        special  = div_zero | ovf;
        // Remainder takes the dividend's sign; product and quotient take sa^sb
        neg      = (bus.funct3_i == F3_REM) ? sa : (sa ^ sb);
        accept   = bus.start_i & (state_q == S_IDLE) & ~bus.flush_i;
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (f3_q[2]),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_step)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = special ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; result_o shows the fixed-up value during the done pulse, then holds it
    always_comb begin
        prod    = neg_q ? (AW'(0) - acc_q) : acc_q;
        quot    = neg_q ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem     = neg_q ? (XLEN'(0) - acc_q[AW-1:XLEN]) : acc_q[AW-1:XLEN];
        res_fix = '0;
        unique case (f3_q)
            F3_MUL:                        res_fix = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  res_fix = prod[AW-1:XLEN];
            F3_DIV, F3_DIVU:               res_fix = quot;
            F3_REM, F3_REMU:               res_fix = rem;
            default:                       res_fix = '0;
        endcase

        bus.ready_o  = (state_q == S_IDLE);
        bus.stall_o  = (state_q == S_BUSY) | (bus.start_i & (state_q == S_IDLE));
        bus.done_o   = (state_q == S_DONE) & ~bus.flush_i;
        bus.result_o = bus.done_o ? res_fix : result_q;
    end

    // Operand latch, iteration datapath and held result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f3_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                f3_q  <= bus.funct3_i;
                cnt_q <= CW'(XLEN);
                neg_q <= special ? 1'b0 : neg;
                if (div_zero) begin
                    // quotient all ones, remainder = dividend
                    acc_q  <= {bus.op_a_i, {XLEN{1'b1}}};
                    opnd_q <= '0;
                end else if (ovf) begin
                    // quotient = dividend, remainder = 0
                    acc_q  <= {{XLEN{1'b0}}, bus.op_a_i};
                    opnd_q <= '0;
                end else if (is_div) begin
                    acc_q  <= {{XLEN{1'b0}}, abs_a};
                    opnd_q <= abs_b;
                end else begin
                    acc_q  <= {{XLEN{1'b0}}, abs_b};
                    opnd_q <= abs_a;
                end
            end else if (state_q == S_BUSY) begin
                if (bus.flush_i) begin
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q - CW'(1);
                end
            end
            if (bus.done_o) begin
                result_q <= res_fix;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    muldiv_seq_if bus ();

    muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.start_i  = 1'b0;
        bus.funct3_i = 3'b000;
        bus.op_a_i   = 32'h0;
        bus.op_b_i   = 32'h0;
        bus.flush_i  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b1 || bus.stall_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b stall=%b done=%b result=%h, required 1 0 0 00000000",
                     bus.ready_o, bus.stall_o, bus.done_o, bus.result_o);
        end
        rst_n = 1'b1;
    endtask

    // Start one op, scramble inputs while busy, wait for done and check latency/result
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int  k;
        bit  seen;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.funct3_i = f;
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        @(negedge clk);
        bus.start_i  = 1'b0;
        bus.funct3_i = ~f;
        bus.op_a_i   = ~a;
        bus.op_b_i   = b + 32'd3;
        k    = 1;
        seen = 1'b0;
        while (k <= 40 && !seen) begin
            if (bus.done_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        checks++;
        if (!seen || k != lat) begin
            errors++;
            $display("FAIL %s_latency: done after %0d cycles (seen=%0b), required %0d", name, k, seen, lat);
        end
        checks++;
        if (bus.result_o !== exp) begin
            errors++;
            $display("FAIL %s_result: got %h, required %h", name, bus.result_o, exp);
        end
    endtask

    task automatic test_mul_timing();
        bit stall_ok;
        bit done_early;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.funct3_i = F3_MUL;
        bus.op_a_i   = 32'd7;
        bus.op_b_i   = 32'hFFFF_FFFD;
        #1;
        checks++;
        if (bus.stall_o !== 1'b1) begin
            errors++;
            $display("FAIL mul_accept_stall: got %b, required 1", bus.stall_o);
        end
        stall_ok   = 1'b1;
        done_early = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (bus.stall_o !== 1'b1 || bus.ready_o !== 1'b0) stall_ok = 1'b0;
            if (bus.done_o !== 1'b0) done_early = 1'b1;
        end
        checks++;
        if (!stall_ok || done_early) begin
            errors++;
            $display("FAIL mul_busy_window: stall_ok=%0b done_early=%0b, required 1 0", stall_ok, done_early);
        end
        @(negedge clk);
        checks++;
        if (bus.done_o !== 1'b1 || bus.stall_o !== 1'b0 || bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL mul_done_cycle: done=%b stall=%b ready=%b, required 1 0 0",
                     bus.done_o, bus.stall_o, bus.ready_o);
        end
        checks++;
        if (bus.result_o !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_result: got %h, required ffffffeb", bus.result_o);
        end
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0 || bus.result_o !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_after_done: ready=%b done=%b result=%h, required 1 0 ffffffeb",
                     bus.ready_o, bus.done_o, bus.result_o);
        end
    endtask

    task automatic test_mul_variants();
        run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh",   F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    endtask

    task automatic test_div();
        run_op("div",  F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem",  F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("divu", F3_DIVU, 32'd100,       32'd7, 32'd14,        33);
        run_op("remu", F3_REMU, 32'd100,       32'd7, 32'd2,         33);
    endtask

    task automatic test_special();
        run_op("divu_by0", F3_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_by0",  F3_REM,  32'd5,         32'd0,         32'd5,         1);
        run_op("div_ovf",  F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    endtask

    // Flush (use_reset=0) or synchronous reset (use_reset=1) at T+10 of a MUL
    task automatic test_abort(input bit use_reset);
        logic [31:0] held;
        logic [31:0] exp_res;
        bit          done_seen;
        string       nm;
        nm = use_reset ? "reset_mid" : "flush";
        @(negedge clk);
        held = bus.result_o;
        exp_res = use_reset ? 32'h0 : held;
        bus.start_i  = 1'b1;
        bus.funct3_i = F3_MUL;
        bus.op_a_i   = 32'd11;
        bus.op_b_i   = 32'd13;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        if (use_reset) rst_n = 1'b0;
        else bus.flush_i = 1'b1;
        @(negedge clk);
        rst_n       = 1'b1;
        bus.flush_i = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.stall_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: ready=%b stall=%b done=%b, required 1 0 0",
                     nm, bus.ready_o, bus.stall_o, bus.done_o);
        end
        done_seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.done_o !== 1'b0) done_seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL %s_no_done: done pulse observed, required none", nm);
        end
        checks++;
        if (bus.result_o !== exp_res) begin
            errors++;
            $display("FAIL %s_result: got %h, required %h", nm, bus.result_o, exp_res);
        end
    endtask

    task automatic test_ignore_start();
        int k;
        bit seen;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.funct3_i = F3_MUL;
        bus.op_a_i   = 32'd3;
        bus.op_b_i   = 32'd5;
        @(negedge clk);
        bus.start_i = 1'b0;
        k = 1;
        seen = 1'b0;
        while (k <= 40 && !seen) begin
            if (k == 5) begin
                bus.start_i  = 1'b1;
                bus.funct3_i = F3_DIVU;
                bus.op_a_i   = 32'd100;
                bus.op_b_i   = 32'd7;
            end else begin
                bus.start_i  = 1'b0;
            end
            if (bus.done_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        bus.start_i = 1'b0;
        checks++;
        if (!seen || k != 33) begin
            errors++;
            $display("FAIL ignore_start_latency: done after %0d cycles (seen=%0b), required 33", k, seen);
        end
        checks++;
        if (bus.result_o !== 32'd15) begin
            errors++;
            $display("FAIL ignore_start_result: got %h, required 0000000f", bus.result_o);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_idle: ready=%b done=%b, required 1 0", bus.ready_o, bus.done_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_mul_timing();
        test_mul_variants();
        test_div();
        test_special();
        test_abort(1'b0);
        test_abort(1'b1);
        test_ignore_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
